// File: rtl/oscillator_pkg.sv
// ---------------------------------------------------------------------------
// oscillator_pkg
//   Shared types for the numerically controlled oscillator.
//   - osc_wave_e      : waveform selector encoding used by the control
//                       register and the shaping logic.
//   - osc_wave_decode : maps the raw 2-bit register field onto osc_wave_e.
// ---------------------------------------------------------------------------
package oscillator_pkg;

   typedef enum logic [1:0] {
      OSC_SQUARE_E   = 2'd0,
      OSC_TRIANGLE_E = 2'd1,
      OSC_SAW_E      = 2'd2,
      OSC_SILENT_E   = 2'd3
   } osc_wave_e;

   // All four codes are legal, so the cast never produces an unnamed value.
   function automatic osc_wave_e osc_wave_decode(input logic [1:0] bits_i);
      return osc_wave_e'(bits_i);
   endfunction

endpackage : oscillator_pkg

// File: rtl/osc_shape.sv
// ---------------------------------------------------------------------------
// osc_shape
//   Purely combinational waveform shaper: turns an accumulator phase into a
//   two's-complement audio sample.
//
//   Ports
//     phase_i  [N_BITS_P]      accumulator phase (unsigned, full circle = 2^N)
//     duty_i   [N_BITS_P]      square-wave high threshold (phase < duty -> high)
//     wave_i   osc_wave_e      waveform selector
//     sample_o [AUDIO_WIDTH_P] signed sample (two's complement bit pattern)
// ---------------------------------------------------------------------------
module osc_shape
   import oscillator_pkg::*;
#(
   parameter int AUDIO_WIDTH_P = 24,
   parameter int N_BITS_P      = 32
) (
   input  logic [N_BITS_P-1:0]      phase_i,
   input  logic [N_BITS_P-1:0]      duty_i,
   input  osc_wave_e                wave_i,
   output logic [AUDIO_WIDTH_P-1:0] sample_o
);

   // Symmetric square levels: +(2^(A-1)-1) and -(2^(A-1)-1), so the wave has
   // no DC offset (the most negative code is deliberately avoided).
   localparam logic [AUDIO_WIDTH_P-1:0] SQ_HIGH_C = {1'b0, {(AUDIO_WIDTH_P-1){1'b1}}};
   localparam logic [AUDIO_WIDTH_P-1:0] SQ_LOW_C  = {1'b1, {(AUDIO_WIDTH_P-2){1'b0}}, 1'b1};

   logic [AUDIO_WIDTH_P-1:0] p_top_w;
   logic [AUDIO_WIDTH_P-1:0] saw_w;
   logic [AUDIO_WIDTH_P-1:0] square_w;
   logic [AUDIO_WIDTH_P-1:0] tri_t_w;
   logic [AUDIO_WIDTH_P-1:0] tri_fold_w;
   logic [AUDIO_WIDTH_P-1:0] triangle_w;

   // Saw: the top bits of the phase are an unsigned ramp; flipping the MSB
   // re-centres it as an offset-binary to two's-complement conversion.
   assign p_top_w = phase_i[N_BITS_P-1 -: AUDIO_WIDTH_P];
   assign saw_w   = {~p_top_w[AUDIO_WIDTH_P-1], p_top_w[AUDIO_WIDTH_P-2:0]};

   assign square_w = (phase_i < duty_i) ? SQ_HIGH_C : SQ_LOW_C;

   // Triangle: take the bits one below the MSB (twice the slope of the saw),
   // mirror them during the second half-period, then re-centre like the saw.
   assign tri_t_w    = phase_i[N_BITS_P-2 -: AUDIO_WIDTH_P];
   assign tri_fold_w = phase_i[N_BITS_P-1] ? ~tri_t_w : tri_t_w;
   assign triangle_w = {~tri_fold_w[AUDIO_WIDTH_P-1], tri_fold_w[AUDIO_WIDTH_P-2:0]};

   always_comb begin
      sample_o = '0;
      case (wave_i)
         OSC_SQUARE_E:   sample_o = square_w;
         OSC_TRIANGLE_E: sample_o = triangle_w;
         OSC_SAW_E:      sample_o = saw_w;
         OSC_SILENT_E:   sample_o = '0;
         default:        sample_o = '0;
      endcase
   end

endmodule : osc_shape

// File: rtl/oscillator_nco.sv
// ---------------------------------------------------------------------------
// oscillator_nco
//   Phase-accumulator oscillator producing one audio sample per sample-rate
//   strobe, delivered over a valid/ready handshake to the mixer.
//
//   Ports
//     clk                    system clock
//     rst                    synchronous active-high reset
//     fs_strobe              one-cycle sample-rate tick
//     cr_osc_waveform_select waveform code (square/triangle/saw/silent)
//     cr_osc_frequency       phase increment per sample
//     cr_osc_duty_cycle      square-wave high threshold
//     cmd_osc_clear_overflow pulse clearing sr_osc_overflow
//     osc_sample             signed sample to the mixer
//     osc_valid / osc_ready  output handshake
//     sr_osc_overflow        sticky "sample dropped" flag
//
//   Timing: strobe in cycle t -> phase updated at the end of t -> shaped
//   combinationally and registered at the end of t+1 -> osc_valid in t+2.
// ---------------------------------------------------------------------------
module oscillator_nco #(
   parameter int AUDIO_WIDTH_P = 24,
   parameter int N_BITS_P      = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     fs_strobe,
   input  logic [1:0]               cr_osc_waveform_select,
   input  logic [N_BITS_P-1:0]      cr_osc_frequency,
   input  logic [N_BITS_P-1:0]      cr_osc_duty_cycle,
   input  logic                     cmd_osc_clear_overflow,
   output logic [AUDIO_WIDTH_P-1:0] osc_sample,
   output logic                     osc_valid,
   input  logic                     osc_ready,
   output logic                     sr_osc_overflow
);

   import oscillator_pkg::*;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                     init_q,   init_d;     // first cycle after reset
   logic [N_BITS_P-1:0]      phase_q,  phase_d;
   logic [N_BITS_P-1:0]      freq_q,   freq_d;     // shadow controls
   logic [N_BITS_P-1:0]      duty_q,   duty_d;
   osc_wave_e                wave_q,   wave_d;
   logic                     pend_q,   pend_d;     // phase updated last cycle
   logic [AUDIO_WIDTH_P-1:0] sample_q, sample_d;
   logic                     valid_q,  valid_d;
   logic                     ovf_q,    ovf_d;

   logic [N_BITS_P:0]        phase_sum_w;
   logic                     load_shadow_w;
   logic                     transfer_w;
   logic [AUDIO_WIDTH_P-1:0] shaped_w;

   // ---------------------------------------------------------------------
   // Waveform shaping from the current phase and shadow controls
   // ---------------------------------------------------------------------
   osc_shape #(
      .AUDIO_WIDTH_P (AUDIO_WIDTH_P),
      .N_BITS_P      (N_BITS_P)
   ) u_shape (
      .phase_i  (phase_q),
      .duty_i   (duty_q),
      .wave_i   (wave_q),
      .sample_o (shaped_w)
   );

   // Extra top bit catches the carry out of the accumulator (phase wrap).
   assign phase_sum_w = {1'b0, phase_q} + {1'b0, freq_q};
   assign transfer_w  = valid_q && osc_ready;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      init_d        = 1'b0;
      phase_d       = phase_q;
      freq_d        = freq_q;
      duty_d        = duty_q;
      wave_d        = wave_q;
      pend_d        = fs_strobe;
      sample_d      = sample_q;
      valid_d       = valid_q;
      ovf_d         = ovf_q;
      load_shadow_w = init_q;

      // Accumulator. Shadows only change at a period boundary (wrap) so a
      // waveform never glitches mid-cycle; a zero frequency never wraps, so
      // it must also accept new settings on every strobe or it would stall.
      if (fs_strobe) begin
         phase_d = phase_sum_w[N_BITS_P-1:0];
         if (phase_sum_w[N_BITS_P] || (freq_q == '0)) begin
            load_shadow_w = 1'b1;
         end
      end

      if (load_shadow_w) begin
         freq_d = cr_osc_frequency;
         duty_d = cr_osc_duty_cycle;
         wave_d = osc_wave_decode(cr_osc_waveform_select);
      end

      // Output register. A completed sample is taken whenever the slot is
      // empty or being emptied this cycle; otherwise it is dropped.
      if (pend_q) begin
         if (!valid_q || osc_ready) begin
            sample_d = shaped_w;
            valid_d  = 1'b1;
         end
      end else if (transfer_w) begin
         valid_d = 1'b0;
      end

      // Sticky overflow; a coinciding drop takes precedence over the clear.
      if (cmd_osc_clear_overflow) begin
         ovf_d = 1'b0;
      end
      if (pend_q && valid_q && !osc_ready) begin
         ovf_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         init_q   <= 1'b1;
         phase_q  <= '0;
         freq_q   <= '0;
         duty_q   <= '0;
         wave_q   <= OSC_SQUARE_E;
         pend_q   <= 1'b0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         init_q   <= init_d;
         phase_q  <= phase_d;
         freq_q   <= freq_d;
         duty_q   <= duty_d;
         wave_q   <= wave_d;
         pend_q   <= pend_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign osc_sample      = sample_q;
   assign osc_valid       = valid_q;
   assign sr_osc_overflow = ovf_q;

endmodule : oscillator_nco

// File: tb/tb_oscillator_nco.sv
// ---------------------------------------------------------------------------
// tb_oscillator_nco
//   Directed self-checking bench for oscillator_nco (A=24, N=32).
// ---------------------------------------------------------------------------
module tb_oscillator_nco;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fs_strobe = 1'b0;
   logic [1:0]  cr_osc_waveform_select = 2'd2;
   logic [31:0] cr_osc_frequency = 32'h0;
   logic [31:0] cr_osc_duty_cycle = 32'h0;
   logic        cmd_osc_clear_overflow = 1'b0;
   logic [23:0] osc_sample;
   logic        osc_valid;
   logic        osc_ready = 1'b1;
   logic        sr_osc_overflow;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   oscillator_nco #(
      .AUDIO_WIDTH_P (24),
      .N_BITS_P      (32)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .fs_strobe              (fs_strobe),
      .cr_osc_waveform_select (cr_osc_waveform_select),
      .cr_osc_frequency       (cr_osc_frequency),
      .cr_osc_duty_cycle      (cr_osc_duty_cycle),
      .cmd_osc_clear_overflow (cmd_osc_clear_overflow),
      .osc_sample             (osc_sample),
      .osc_valid              (osc_valid),
      .osc_ready              (osc_ready),
      .sr_osc_overflow        (sr_osc_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Signed value -> 24-bit two's-complement pattern.
   function automatic logic [23:0] s24(input int v);
      logic [31:0] t;
      t = v;
      return t[23:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] sel, input logic [31:0] fr, input logic [31:0] du);
      cr_osc_waveform_select = sel;
      cr_osc_frequency       = fr;
      cr_osc_duty_cycle      = du;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   // One strobe with ready=1; checks the two-cycle latency, returns sample.
   task automatic strobe_get(input string tag, output logic [23:0] s);
      fs_strobe = 1'b1;
      tick();
      fs_strobe = 1'b0;
      chk({tag, "_lat1"}, {31'd0, osc_valid}, 32'd0);
      tick();
      chk({tag, "_lat2"}, {31'd0, osc_valid}, 32'd1);
      s = osc_sample;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] s;

      // ---------------- reset state ----------------
      rst = 1'b1;
      tick();
      tick();
      chk("rst_valid",  {31'd0, osc_valid}, 32'd0);
      chk("rst_sample", {8'd0, osc_sample}, 32'd0);
      chk("rst_ovf",    {31'd0, sr_osc_overflow}, 32'd0);

      // ---------------- saw ----------------
      do_reset(2'd2, 32'h1000_0000, 32'h0);
      for (int k = 1; k <= 17; k++) begin
         strobe_get($sformatf("saw%0d", k), s);
         chk($sformatf("saw%0d", k), {8'd0, s}, {8'd0, s24(-32'sh80_0000 + (k % 16) * 32'sh10_0000)});
      end
      // back-to-back strobes: valid stays high, one sample per strobe
      fs_strobe = 1'b1;
      tick();
      chk("b2b_v0", {31'd0, osc_valid}, 32'd0);
      tick();
      chk("b2b_s18", {8'd0, osc_sample}, {8'd0, s24(-32'sh60_0000)});
      tick();
      fs_strobe = 1'b0;
      chk("b2b_v19", {31'd0, osc_valid}, 32'd1);
      chk("b2b_s19", {8'd0, osc_sample}, {8'd0, s24(-32'sh50_0000)});
      tick();
      chk("b2b_v20", {31'd0, osc_valid}, 32'd1);
      chk("b2b_s20", {8'd0, osc_sample}, {8'd0, s24(-32'sh40_0000)});
      tick();
      chk("b2b_idle", {31'd0, osc_valid}, 32'd0);

      // ---------------- square ----------------
      do_reset(2'd0, 32'h1000_0000, 32'h4000_0000);
      for (int k = 1; k <= 16; k++) begin
         strobe_get($sformatf("sq%0d", k), s);
         chk($sformatf("sq%0d", k), {8'd0, s},
             ((k % 16) < 4) ? 32'h007F_FFFF : 32'h0080_0001);
      end

      // ---------------- triangle ----------------
      do_reset(2'd1, 32'h0800_0000, 32'h0);
      for (int k = 1; k <= 32; k++) begin
         strobe_get($sformatf("tri%0d", k), s);
         if (k == 4)  chk("tri_p20", {8'd0, s}, 32'h00C0_0000);
         if (k == 8)  chk("tri_p40", {8'd0, s}, 32'h0000_0000);
         if (k == 16) chk("tri_p80", {8'd0, s}, 32'h007F_FFFF);
         if (k == 24) chk("tri_pC0", {8'd0, s}, 32'h00FF_FFFF);
         if (k == 32) chk("tri_p00", {8'd0, s}, 32'h0080_0000);
      end

      // ---------------- silent ----------------
      do_reset(2'd3, 32'h1000_0000, 32'h0);
      strobe_get("sil1", s);
      chk("sil1", {8'd0, s}, 32'd0);

      // ---------------- shadow registers ----------------
      do_reset(2'd2, 32'h1000_0000, 32'h0);
      for (int k = 1; k <= 18; k++) begin
         strobe_get($sformatf("shd%0d", k), s);
         if (k == 3)  cr_osc_frequency = 32'h2000_0000;
         if (k == 4)  chk("shd4",  {8'd0, s}, {8'd0, s24(-32'sh40_0000)});
         if (k == 15) chk("shd15", {8'd0, s}, {8'd0, s24(32'sh70_0000)});
         if (k == 16) chk("shd16", {8'd0, s}, {8'd0, s24(-32'sh80_0000)});
         if (k == 17) chk("shd17", {8'd0, s}, {8'd0, s24(-32'sh60_0000)});
         if (k == 18) chk("shd18", {8'd0, s}, {8'd0, s24(-32'sh40_0000)});
      end

      // ---------------- backpressure / overflow ----------------
      do_reset(2'd2, 32'h1000_0000, 32'h0);
      osc_ready = 1'b0;
      strobe_get("bp_a", s);
      chk("bp_a", {8'd0, s}, {8'd0, s24(-32'sh70_0000)});
      fs_strobe = 1'b1;
      tick();
      fs_strobe = 1'b0;
      tick();
      chk("bp_hold_s", {8'd0, osc_sample}, {8'd0, s24(-32'sh70_0000)});
      chk("bp_hold_v", {31'd0, osc_valid}, 32'd1);
      chk("bp_ovf",    {31'd0, sr_osc_overflow}, 32'd1);
      osc_ready = 1'b1;
      tick();
      chk("bp_xfer_v", {31'd0, osc_valid}, 32'd0);
      chk("bp_ovf_sticky", {31'd0, sr_osc_overflow}, 32'd1);
      cmd_osc_clear_overflow = 1'b1;
      tick();
      cmd_osc_clear_overflow = 1'b0;
      chk("bp_clear", {31'd0, sr_osc_overflow}, 32'd0);
      osc_ready = 1'b0;
      strobe_get("bp_c", s);
      chk("bp_c", {8'd0, s}, {8'd0, s24(-32'sh50_0000)});
      fs_strobe = 1'b1;
      tick();
      fs_strobe = 1'b0;
      cmd_osc_clear_overflow = 1'b1;
      tick();
      cmd_osc_clear_overflow = 1'b0;
      chk("bp_set_wins", {31'd0, sr_osc_overflow}, 32'd1);
      chk("bp_c_hold",   {8'd0, osc_sample}, {8'd0, s24(-32'sh50_0000)});

      // ---------------- reset mid-handshake / mid-pipeline ----------------
      do_reset(2'd2, 32'h1000_0000, 32'h0);
      osc_ready = 1'b0;
      strobe_get("rs_a", s);
      fs_strobe = 1'b1;
      tick();
      fs_strobe = 1'b0;
      tick();
      chk("rs_pre_ovf", {31'd0, sr_osc_overflow}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_valid",  {31'd0, osc_valid}, 32'd0);
      chk("rs_ovf",    {31'd0, sr_osc_overflow}, 32'd0);
      chk("rs_sample", {8'd0, osc_sample}, 32'd0);
      tick();
      tick();
      tick();
      chk("rs_quiet", {31'd0, osc_valid}, 32'd0);
      // strobe coinciding with reset is ignored
      rst = 1'b1;
      fs_strobe = 1'b1;
      tick();
      rst = 1'b0;
      fs_strobe = 1'b0;
      tick();
      tick();
      chk("rs_strobe_ign", {31'd0, osc_valid}, 32'd0);
      // reset while a sample is in the pipeline
      fs_strobe = 1'b1;
      tick();
      fs_strobe = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rs_pipe0", {31'd0, osc_valid}, 32'd0);
      tick();
      chk("rs_pipe1", {31'd0, osc_valid}, 32'd0);
      // phase restarted from 0
      osc_ready = 1'b1;
      strobe_get("rs_after", s);
      chk("rs_after", {8'd0, s}, {8'd0, s24(-32'sh70_0000)});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_oscillator_nco
